register_file: RTL
==================

Name: register_file

Overview:
- Parametrised successor to the single load register: an array of DEPTH registers, each WIDTH bits wide.
- One synchronous write port, two registered read ports, and a synchronous bulk-clear.
- Optional write-to-read bypass and an optional hardwired-zero entry 0.
- A per-entry written-flag vector lets datapath control logic see which entries hold valid data since the last reset or clear.

Parameters:
- WIDTH, 8, data width of each entry in bits.
- DEPTH, 8, number of entries (2..256).
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 0, when 1 entry 0 always reads zero and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to the address being read is forwarded to the read data.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- clr  input  1  synchronous clear of all entries and flags.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  ADDR_W  read address, port A.
- re_b  input  1  read enable, port B.
- raddr_b  input  ADDR_W  read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rdata_b  output  WIDTH  registered read data, port B.
- written  output  DEPTH  bit i = 1 if entry i has been written since the last reset or clr.
- err  output  1  sticky out-of-range access flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - all entries = 0; rdata_a = rdata_b = 0; written = 0; err = 0.
  - Deassertion is sampled at the next rising edge.
  - Reset mid-operation discards any write in flight.
- Write:
  - On a rising edge with we=1 and waddr < DEPTH: entry[waddr] <= wdata and written[waddr] <= 1.
  - With ZERO_REG=1 and waddr=0: no update and written[0] stays 0; this is not an error.
- Read, 1-cycle latency:
  - On a rising edge with re_x=1: rdata_x <= entry[raddr_x], using the value before that edge's write.
  - With re_x=0: rdata_x holds its previous value.
- Bypass:
  - When BYPASS=1, we=1, re_x=1 and raddr_x == waddr on the same edge: rdata_x <= wdata.
  - The zero-register rule below takes priority.
  - When BYPASS=0 the old contents are returned.
- Zero register: with ZERO_REG=1, any read of address 0 returns 0 regardless of bypass.
- Dual read: ports A and B are independent; the same address on both is legal and both return identical data.
- Clear (clr=1 on an edge):
  - all entries <= 0 and written <= 0.
  - rdata_a and rdata_b <= 0 if their re is high, otherwise they hold.
  - clr has priority over a simultaneous write (the write is dropped) and over bypass.
  - err is not cleared; only rst clears it.
- Out of range (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - The write is ignored.
  - A read returns 0.
  - err <= 1 on that edge and stays set until rst.
- Outputs are glitch-free and come directly from flops.
- There is no combinational path from any input to any output.

Test Plan:
- Reset then idle:
  - Hold rst=0 for 2 cycles, release, then read all addresses on both ports.
  - Required: rdata = 8'h00 everywhere, written = 8'h00, err = 0.
- Write/read back:
  - Write 8'h55 to addr 3 and 8'hAA to addr 5, then on the next edge read A=3, B=5.
  - Required: one cycle later rdata_a = 8'h55, rdata_b = 8'hAA, written = 8'b0010_1000.
- Bypass:
  - Same edge: we=1, waddr=2, wdata=8'hFF, re_a=1, raddr_a=2 (old contents 8'h11).
  - Required: BYPASS=1 gives rdata_a = 8'hFF; BYPASS=0 gives rdata_a = 8'h11 and the next read gives 8'hFF.
- Zero register:
  - ZERO_REG=1: write 8'h77 to addr 0, then read addr 0 on both ports, including a same-edge bypass attempt.
  - Required: rdata = 8'h00, written[0] = 0, err = 0.
- Clear priority:
  - Fill addrs 1..7, then assert clr together with we=1 (addr 4, 8'hC3) and re_b=1 (raddr_b=4).
  - Required: rdata_b = 8'h00, written = 0, and subsequent reads of 1..7 return 8'h00.
- Reset mid-operation and range check:
  - DEPTH=6: write addr 7 -> err = 1, entries unchanged, and a read of addr 7 returns 8'h00.
  - Then pull rst low asynchronously between edges.
  - Required: rdata, written and err go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_file.sv
// Parametrised register file: one synchronous write port, two registered read
// ports, bulk clear, optional bypass and hardwired-zero entry, sticky range error.
module register_file #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [DEPTH-1:0]  written,
  output logic              err
);

  // Storage spans the whole address space; entries at or above DEPTH are never written.
  localparam int SLOTS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [SLOTS];
  logic [SLOTS-1:0] written_q;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             w_in_range;
  logic             a_in_range;
  logic             b_in_range;
  logic             write_ok;
  logic             access_err;

  function automatic logic [WIDTH-1:0] read_value(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored,
    input logic              in_range
  );
    if (!in_range)
      return '0;
    if (ZERO_REG != 0 && addr == '0)
      return '0;
    if (BYPASS != 0 && we && addr == waddr)
      return wdata;
    return stored;
  endfunction

  always_comb begin
    w_in_range = {1'b0, waddr} < DEPTH_V;
    a_in_range = {1'b0, raddr_a} < DEPTH_V;
    b_in_range = {1'b0, raddr_b} < DEPTH_V;
    write_ok   = we && w_in_range && !(ZERO_REG != 0 && waddr == '0);
    access_err = (we && !w_in_range) || (re_a && !a_in_range) || (re_b && !b_in_range);
    next_a     = read_value(raddr_a, mem[raddr_a], a_in_range);
    next_b     = read_value(raddr_b, mem[raddr_b], b_in_range);
  end

  // Clear beats both the write and the bypass; err is only released by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLOTS; i++)
        mem[i] <= '0;
      written_q <= '0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      err       <= 1'b0;
    end else begin
      if (re_a)
        rdata_a <= clr ? '0 : next_a;
      if (re_b)
        rdata_b <= clr ? '0 : next_b;
      if (access_err)
        err <= 1'b1;
      if (clr) begin
        for (int i = 0; i < SLOTS; i++)
          mem[i] <= '0;
        written_q <= '0;
      end else if (write_ok) begin
        mem[waddr]       <= wdata;
        written_q[waddr] <= 1'b1;
      end
    end
  end

  assign written = written_q[DEPTH-1:0];

endmodule
